// File: rtl/rf_mp.sv
// Multi-port register file with write-to-read bypass, busy scoreboard and
// a run-time clear sequencer that zeroes one register per cycle.
module rf_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     wr_ready,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_addr,
  output logic [NUM_REGS-1:0]      busy,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic                clr_done_q, clr_done_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  logic [AW-1:0]       wa [NUM_WR];
  logic [DATA_W-1:0]   wd [NUM_WR];
  logic [NUM_WR-1:0]   wr_ok;
  logic [AW-1:0]       ra [NUM_RD];
  logic [DATA_W-1:0]   rv [NUM_RD];
  logic                idle;
  logic                alloc_ok;

  assign idle     = (state_q == ST_IDLE);
  assign wr_ready = idle;
  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_done = clr_done_q;
  assign busy     = busy_q;
  assign alloc_ok = alloc_en && idle && !(ZERO_REG && (alloc_addr == '0));

  // Unpack write ports and qualify each write (ready, not to hardwired r0)
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wa[j]    = wr_addr[j*AW +: AW];
      wd[j]    = wr_data[j*DATA_W +: DATA_W];
      wr_ok[j] = wr_en[j] && idle && !(ZERO_REG && (wa[j] == '0));
    end
  end

  // Combinational read with bypass; higher-index write port overrides lower
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra[i] = rd_addr[i*AW +: AW];
      rv[i] = regs_q[ra[i]];
      if (BYPASS && idle) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wa[j] == ra[i])) rv[i] = wd[j];
        end
      end
      if (ZERO_REG && (ra[i] == '0)) rv[i] = '0;
      rd_data[i*DATA_W +: DATA_W] = rv[i];
    end
  end

  // Register array next state: writes when idle, one zeroed entry per clear cycle
  always_comb begin
    regs_d = regs_q;
    if (state_q == ST_CLEAR) begin
      regs_d[idx_q] = '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) regs_d[wa[j]] = wd[j];
      end
    end
  end

  // Scoreboard next state: writes retire, alloc wins, clear start wipes all
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_ok[j]) busy_d[wa[j]] = 1'b0;
    end
    if (alloc_ok) busy_d[alloc_addr] = 1'b1;
    if (idle && clr_req) busy_d = '0;
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  // Clear sequencer next state
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NUM_REGS - 1)) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      clr_done_q <= 1'b0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_done_q <= clr_done_d;
      busy_q     <= busy_d;
    end
  end

  // Register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_rf_mp.sv
// Randomised scoreboard bench for rf_mp (2 read ports, 2 write ports).
module tb_rf_mp;

  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 32;
  localparam int unsigned NRD = 2;
  localparam int unsigned NWR = 2;
  localparam bit          ZR  = 1'b1;
  localparam bit          BP  = 1'b1;
  localparam int unsigned AW  = 5;

  logic               clk;
  logic               rst_n;
  logic [NRD*AW-1:0]  rd_addr;
  logic [NRD*DW-1:0]  rd_data;
  logic [NWR-1:0]     wr_en;
  logic [NWR*AW-1:0]  wr_addr;
  logic [NWR*DW-1:0]  wr_data;
  logic               wr_ready;
  logic               alloc_en;
  logic [AW-1:0]      alloc_addr;
  logic [NR-1:0]      busy;
  logic               clr_req;
  logic               clr_busy;
  logic               clr_done;

  rf_mp #(
    .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR),
    .ZERO_REG(ZR), .BYPASS(BP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy(busy),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NRD*DW-1:0] rd;
    logic [NR-1:0]     bsy;
    logic              rdy;
    logic              cb;
    logic              cd;
    int                id;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_id = 0;

  // Reference model state: architectural contents and clear progress
  logic [DW-1:0] m_mem [NR];
  logic [NR-1:0] m_busy;
  bit            m_clr;
  int            m_idx;
  bit            m_done;

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_mem[r] = '0;
    m_busy = '0;
    m_clr  = 1'b0;
    m_idx  = 0;
    m_done = 1'b0;
  endtask

  // One clock cycle of stimulus with expected response
  task automatic cyc(input logic [NWR-1:0] we, input logic [NWR*AW-1:0] wa,
                     input logic [NWR*DW-1:0] wd, input logic al,
                     input logic [AW-1:0] aa, input logic clr,
                     input logic [NRD*AW-1:0] ra);
    exp_t          e;
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    @(posedge clk);
    #1;
    rst_n = 1'b1; wr_en = we; wr_addr = wa; wr_data = wd;
    alloc_en = al; alloc_addr = aa; clr_req = clr; rd_addr = ra;
    for (int i = 0; i < NRD; i++) begin
      a = ra[i*AW +: AW];
      if (ZR && a == '0) v = '0;
      else begin
        v = m_mem[a];
        if (BP && !m_clr)
          for (int j = 0; j < NWR; j++)
            if (we[j] && wa[j*AW +: AW] == a) v = wd[j*DW +: DW];
      end
      e.rd[i*DW +: DW] = v;
    end
    e.bsy = m_busy; e.rdy = !m_clr; e.cb = m_clr; e.cd = m_done; e.id = cyc_id;
    cyc_id++;
    q.push_back(e);
    if (m_clr) begin
      m_mem[m_idx] = '0;
      m_idx++;
      m_done = (m_idx == NR);
      if (m_done) m_clr = 1'b0;
    end else begin
      m_done = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        a = wa[j*AW +: AW];
        if (we[j] && !(ZR && a == '0)) begin
          m_mem[a]  = wd[j*DW +: DW];
          m_busy[a] = 1'b0;
        end
      end
      if (al && !(ZR && aa == '0)) m_busy[aa] = 1'b1;
      if (clr) begin
        m_clr = 1'b1; m_idx = 0; m_busy = '0;
      end
    end
  endtask

  // One cycle held in reset; the DUT must show reset state immediately
  task automatic rst_cyc(input logic [NRD*AW-1:0] ra);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b0; wr_en = '0; alloc_en = 1'b0; clr_req = 1'b0; rd_addr = ra;
    model_reset();
    e.rd = '0; e.bsy = '0; e.rdy = 1'b1; e.cb = 1'b0; e.cd = 1'b0; e.id = cyc_id;
    cyc_id++;
    q.push_back(e);
  endtask

  task automatic idle(input logic [NRD*AW-1:0] ra);
    cyc('0, '0, '0, 1'b0, '0, 1'b0, ra);
  endtask

  function automatic logic [AW-1:0] raddr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom);
  endfunction

  task automatic rnd_cyc(input bit allow_clr);
    logic [NWR*AW-1:0] wa;
    logic [NRD*AW-1:0] ra;
    logic              clr;
    logic              al;
    for (int j = 0; j < NWR; j++) wa[j*AW +: AW] = raddr();
    for (int i = 0; i < NRD; i++) ra[i*AW +: AW] = raddr();
    clr = allow_clr && ($urandom_range(0, 29) == 0);
    al  = clr ? 1'b0 : 1'($urandom_range(0, 1));
    cyc(NWR'($urandom), wa, {$urandom, $urandom}, al, raddr(), clr, ra);
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        total += 5;
        if (rd_data !== e.rd) begin
          bad++;
          $display("FAIL rd_data cyc=%0d got=%h want=%h", e.id, rd_data, e.rd);
        end
        if (busy !== e.bsy) begin
          bad++;
          $display("FAIL busy cyc=%0d got=%h want=%h", e.id, busy, e.bsy);
        end
        if (wr_ready !== e.rdy) begin
          bad++;
          $display("FAIL wr_ready cyc=%0d got=%b want=%b", e.id, wr_ready, e.rdy);
        end
        if (clr_busy !== e.cb) begin
          bad++;
          $display("FAIL clr_busy cyc=%0d got=%b want=%b", e.id, clr_busy, e.cb);
        end
        if (clr_done !== e.cd) begin
          bad++;
          $display("FAIL clr_done cyc=%0d got=%b want=%b", e.id, clr_done, e.cd);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; clr_req = 1'b0; rd_addr = '0;
    model_reset();

    // reset state, then every address on both ports
    rst_cyc({5'd1, 5'd0});
    rst_cyc({5'd31, 5'd17});
    for (int k = 0; k < 16; k++) idle({AW'(2*k + 1), AW'(2*k)});
    for (int k = 0; k < 16; k++) idle({AW'(2*k), AW'(2*k + 1)});

    // bypass of r5, then stored value; writes to r0 read back 0
    cyc(2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 1'b0, '0, 1'b0, {5'd0, 5'd5});
    idle({5'd5, 5'd5});
    cyc(2'b01, {5'd0, 5'd0}, {32'h0, 32'h1234}, 1'b0, '0, 1'b0, {5'd0, 5'd0});
    idle({5'd0, 5'd5});

    // both ports write r7: port 1 wins for bypass and storage
    cyc(2'b11, {5'd7, 5'd7}, {32'h22, 32'h11}, 1'b0, '0, 1'b0, {5'd7, 5'd7});
    idle({5'd7, 5'd5});

    // scoreboard: alloc, alloc+write, write alone
    cyc('0, '0, '0, 1'b1, 5'd3, 1'b0, {5'd3, 5'd3});
    cyc(2'b01, {5'd0, 5'd3}, {32'h0, 32'h33}, 1'b1, 5'd3, 1'b0, {5'd3, 5'd3});
    idle({5'd3, 5'd3});
    cyc(2'b10, {5'd3, 5'd0}, {32'h44, 32'h0}, 1'b0, '0, 1'b0, {5'd3, 5'd3});
    idle({5'd3, 5'd3});
    cyc('0, '0, '0, 1'b1, 5'd0, 1'b0, {5'd0, 5'd0});
    idle({5'd0, 5'd0});

    // fill r1..r31 with their index, clear with writes hammering, read back
    for (int k = 1; k < 32; k += 2)
      cyc(2'b11, {AW'(k + 1), AW'(k)}, {DW'(k + 1), DW'(k)}, 1'b0, '0, 1'b0, {AW'(k), AW'(k)});
    for (int k = 0; k < 8; k++) cyc('0, '0, '0, 1'b1, AW'(k + 8), 1'b0, {AW'(k), AW'(k + 8)});
    idle({5'd31, 5'd2});
    cyc('0, '0, '0, 1'b0, '0, 1'b1, {5'd31, 5'd1});
    for (int k = 0; k < 34; k++) rnd_cyc(1'b0);
    for (int k = 0; k < 16; k++) idle({AW'(2*k + 1), AW'(2*k)});

    // reset at clear cycle 10, then an immediate write after release
    for (int k = 1; k < 32; k++) cyc(2'b01, {5'd0, AW'(k)}, {32'h0, DW'(k * 3)}, 1'b0, '0, 1'b0, {AW'(k), 5'd9});
    cyc('0, '0, '0, 1'b0, '0, 1'b1, {5'd20, 5'd1});
    for (int k = 0; k < 10; k++) rnd_cyc(1'b0);
    rst_cyc({5'd20, 5'd9});
    cyc(2'b01, {5'd0, 5'd9}, {32'h0, 32'hABCD}, 1'b1, 5'd9, 1'b0, {5'd20, 5'd9});
    idle({5'd20, 5'd9});
    for (int k = 0; k < 36; k++) idle({5'd31, AW'(k)});

    // random traffic with occasional clears and resets
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 199) == 0) rst_cyc({raddr(), raddr()});
      else rnd_cyc(1'b1);
    end
    // clr_req held high across clr_done to chain a second clear
    for (int k = 0; k < 70; k++) cyc('0, '0, '0, 1'b0, '0, 1'b1, {AW'(k), AW'(k + 1)});
    for (int k = 0; k < 40; k++) rnd_cyc(1'b0);

    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_mp.md
Name: rf_mp

Overview:
- Parametrised multi-port register file for the RISC-V CPU, with configurable width, depth, read-port count and write-port count.
- Adds same-cycle write-to-read bypass, a per-register busy scoreboard for hazard detection, and a run-time clear sequencer.
- Sits between decode (read ports, busy lookup) and writeback (write ports).

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, register count; power of 2, at least 2. Local AW = $clog2(NUM_REGS).
- NUM_RD, 2, number of read ports, 1 to 4.
- NUM_WR, 1, number of write ports, 1 to 2.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*AW  read addresses; port i = bits [i*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  read data; port i = bits [i*DATA_W +: DATA_W].
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- wr_ready  out  1  1 = writes and allocs are accepted this cycle.
- alloc_en  in  1  mark a destination register busy.
- alloc_addr  in  AW  register to mark busy.
- busy  out  NUM_REGS  scoreboard; bit r = register r has a write pending.
- clr_req  in  1  request zeroing of all registers.
- clr_busy  out  1  clear sequence in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low; ports are named clk and rst_n.
- On reset assertion, immediately:
  - all registers = 0, busy = 0, FSM = IDLE, clr_busy = 0, clr_done = 0, wr_ready = 1.
- Reset mid-clear aborts the sequence with no clr_done pulse.
- Reads are combinational (0-cycle latency).
- Read value, per port:
  - ZERO_REG=1 and address 0: returns 0; bypass is never applied.
  - Else BYPASS=1, wr_ready=1, and an enabled write to the same address this cycle: returns that write data.
  - Else: returns the stored value.
- Writes: when wr_en[j]=1 and wr_ready=1, the register is updated at the next edge.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Write conflict: several ports write the same address in one cycle -> highest-index port wins, for both storage and bypass.
- Scoreboard updates, at each edge:
  - An accepted write to r clears busy[r].
  - An accepted alloc_en to alloc_addr sets busy[alloc_addr].
  - Alloc and write to the same r in the same cycle -> busy[r] = 1 (alloc wins).
  - With ZERO_REG=1, busy[0] is constant 0 and allocs to 0 are dropped.
- FSM states: IDLE, CLEAR.
- IDLE -> CLEAR: when clr_req=1. At that edge:
  - idx = 0, busy = 0.
  - Any write or alloc presented that same cycle is still committed; that write's value is later overwritten by the clear.
- While in CLEAR:
  - clr_busy = 1, wr_ready = 0; wr_en and alloc_en are ignored.
  - Each edge sets reg[idx] = 0 and idx += 1.
  - Reads return stored values (partially cleared); no bypass.
  - clr_req is ignored.
- CLEAR -> IDLE: at the edge that zeroes reg[NUM_REGS-1]. clr_done = 1 for exactly the following cycle.
- Timing: CLEAR lasts NUM_REGS cycles. clr_req held high after clr_done starts a new clear.
- Sizing: NUM_REGS x DATA_W flops plus NUM_REGS busy flops. No reset-time sequencing needed; reset clears everything directly.

Test Plan:
- Reset, then read all addresses on every port -> all 0, busy = 0, wr_ready = 1.
- Write 0xDEADBEEF to r5 and read r5 in the same cycle:
  - BYPASS=1 -> 0xDEADBEEF that cycle.
  - BYPASS=0 -> 0 that cycle, 0xDEADBEEF next cycle.
  - A write of 0x1234 to r0 reads back 0 in both configurations.
- NUM_WR=2, both ports write r7 (port0 0x11, port1 0x22) -> read r7 = 0x22, both bypassed and stored.
- Scoreboard:
  - alloc r3 -> busy[3]=1 next cycle.
  - alloc r3 and write r3 together -> busy[3] stays 1.
  - A later write to r3 alone -> busy[3]=0.
- Fill r1..r31 with the index value, pulse clr_req -> clr_busy=1 for 32 cycles, writes ignored during that time, clr_done pulses once, then all reads = 0 and busy = 0.
- Assert rst_n=0 at clear cycle 10, release -> IDLE, all registers 0, no clr_done pulse; writes are accepted immediately after release.
